// File: rtl/rgb_to_yuv_ds_if.sv
// rgb_to_yuv_ds_if: SRAM port plus RY_enable/RY_complete handshake.
// master = converter (owns SRAM), slave = top FSM / SRAM side.
interface rgb_to_yuv_ds_if;
  logic        SRAM_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        RY_enable;
  logic        RY_complete;

  modport master (
    output SRAM_we_n,
    output SRAM_address,
    output SRAM_write_data,
    output RY_complete,
    input  SRAM_read_data,
    input  RY_enable
  );

  modport slave (
    input  SRAM_we_n,
    input  SRAM_address,
    input  SRAM_write_data,
    input  RY_complete,
    output SRAM_read_data,
    output RY_enable
  );
endinterface

// File: rtl/rgb_to_yuv_ds.sv
// rgb_to_yuv_ds: interleaved RGB in SRAM -> planar Y, U/2, V/2 in SRAM.
// Ports: Clock, Resetn (async, low), bus (SRAM port + enable/complete).
module rgb_to_yuv_ds #(
  parameter logic [17:0] Y_START_ADDRESS   = 18'd0,
  parameter logic [17:0] U_START_ADDRESS   = 18'd38400,
  parameter logic [17:0] V_START_ADDRESS   = 18'd57600,
  parameter logic [17:0] RGB_START_ADDRESS = 18'd146944,
  parameter int          NUM_GROUPS        = 19200
) (
  input  logic Clock,
  input  logic Resetn,
  rgb_to_yuv_ds_if.master bus
);

  localparam int GW = $clog2(NUM_GROUPS + 1);
  localparam logic [GW-1:0] LAST = GW'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GROUP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_Y,
    C_U,
    C_V
  } comp_t;

  state_t state;
  logic [3:0] cyc;
  logic [GW-1:0] grp;
  logic we_n;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic complete;

  logic [5:0][15:0] word;
  logic [5:0][15:0] wv;
  logic [3:0][7:0] y_q, u_q, v_q;
  logic [3:0][7:0] y_n, u_n, v_n;

  logic slot_on;
  logic [1:0] pix;
  comp_t comp;
  logic [7:0] r, g, b;
  logic signed [31:0] k_r, k_g, k_b, k_off;
  logic signed [31:0] p_r, p_g, p_b, sum;
  logic [7:0] res;

  logic [17:0] g18, rd_next, rd_first;

  function automatic logic [7:0] avg2(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, z} + 9'd1;
    return s[8:1];
  endfunction

  assign g18 = 18'(grp);
  assign rd_next = RGB_START_ADDRESS + 18'd6 * g18
                 + 18'(cyc) + 18'd1;
  assign rd_first = RGB_START_ADDRESS
                  + 18'd6 * (g18 + 18'd1);

  // Word k lands on the bus at c=k+2; use it live that cycle,
  // from the capture register afterwards.
  always_comb begin
    wv = word;
    for (int k = 0; k < 6; k++)
      if (cyc == 4'(k + 2)) wv[k] = bus.SRAM_read_data;
  end

  // One output sample per cycle on c=3..14, ordered so each
  // pixel is complete and each result is ready for its write.
  always_comb begin
    slot_on = 1'b0;
    pix = 2'd0;
    comp = C_Y;
    if (state == S_GROUP) begin
      slot_on = 1'b1;
      unique case (cyc)
        4'd3:  begin pix = 2'd0; comp = C_Y; end
        4'd4:  begin pix = 2'd1; comp = C_Y; end
        4'd5:  begin pix = 2'd0; comp = C_U; end
        4'd6:  begin pix = 2'd2; comp = C_Y; end
        4'd7:  begin pix = 2'd3; comp = C_Y; end
        4'd8:  begin pix = 2'd1; comp = C_U; end
        4'd9:  begin pix = 2'd2; comp = C_U; end
        4'd10: begin pix = 2'd3; comp = C_U; end
        4'd11: begin pix = 2'd0; comp = C_V; end
        4'd12: begin pix = 2'd1; comp = C_V; end
        4'd13: begin pix = 2'd2; comp = C_V; end
        4'd14: begin pix = 2'd3; comp = C_V; end
        default: slot_on = 1'b0;
      endcase
    end
  end

  always_comb begin
    r = wv[0][15:8];
    g = wv[0][7:0];
    b = wv[1][15:8];
    unique case (pix)
      2'd1: begin
        r = wv[1][7:0];
        g = wv[2][15:8];
        b = wv[2][7:0];
      end
      2'd2: begin
        r = wv[3][15:8];
        g = wv[3][7:0];
        b = wv[4][15:8];
      end
      2'd3: begin
        r = wv[4][7:0];
        g = wv[5][15:8];
        b = wv[5][7:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    k_r = 32'sd16843;
    k_g = 32'sd33030;
    k_b = 32'sd6423;
    k_off = 32'sd1048576;
    unique case (comp)
      C_U: begin
        k_r = -32'sd9699;
        k_g = -32'sd19071;
        k_b = 32'sd28770;
        k_off = 32'sd8388608;
      end
      C_V: begin
        k_r = 32'sd28770;
        k_g = -32'sd24117;
        k_b = -32'sd4653;
        k_off = 32'sd8388608;
      end
      default: ;
    endcase
  end

  assign p_r = k_r * $signed({24'd0, r});
  assign p_g = k_g * $signed({24'd0, g});
  assign p_b = k_b * $signed({24'd0, b});
  assign sum = p_r + p_g + p_b + k_off + 32'sd32768;

  // Negative -> 0; anything at or above 256.0 -> 255.
  always_comb begin
    if (sum < 0)
      res = 8'd0;
    else if (sum > 32'sh00FF_FFFF)
      res = 8'd255;
    else
      res = sum[23:16];
  end

  // Forward the current slot so a write can use it same cycle.
  always_comb begin
    y_n = y_q;
    u_n = u_q;
    v_n = v_q;
    if (slot_on) begin
      unique case (comp)
        C_Y: y_n[pix] = res;
        C_U: u_n[pix] = res;
        default: v_n[pix] = res;
      endcase
    end
  end

  // Output registers are loaded one cycle ahead of the slot c
  // they belong to.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      cyc <= 4'd0;
      grp <= '0;
      we_n <= 1'b1;
      addr <= 18'd0;
      wdata <= 16'd0;
      complete <= 1'b0;
      word <= '0;
      y_q <= '0;
      u_q <= '0;
      v_q <= '0;
    end else begin
      y_q <= y_n;
      u_q <= u_n;
      v_q <= v_n;
      if (state == S_GROUP) begin
        for (int k = 0; k < 6; k++)
          if (cyc == 4'(k + 2)) word[k] <= bus.SRAM_read_data;
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.RY_enable) begin
            state <= S_GROUP;
            cyc <= 4'd0;
            grp <= '0;
            complete <= 1'b0;
            we_n <= 1'b1;
            addr <= RGB_START_ADDRESS;
          end
        end
        S_GROUP: begin
          cyc <= cyc + 4'd1;
          we_n <= 1'b1;
          unique case (cyc)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4:
              addr <= rd_next;
            4'd11: begin
              we_n <= 1'b0;
              addr <= Y_START_ADDRESS + g18 + g18;
              wdata <= {y_n[0], y_n[1]};
            end
            4'd12: begin
              we_n <= 1'b0;
              addr <= Y_START_ADDRESS + g18 + g18 + 18'd1;
              wdata <= {y_n[2], y_n[3]};
            end
            4'd13: begin
              we_n <= 1'b0;
              addr <= U_START_ADDRESS + g18;
              wdata <= {avg2(u_n[0], u_n[1]),
                        avg2(u_n[2], u_n[3])};
            end
            4'd14: begin
              we_n <= 1'b0;
              addr <= V_START_ADDRESS + g18;
              wdata <= {avg2(v_n[0], v_n[1]),
                        avg2(v_n[2], v_n[3])};
            end
            4'd15: begin
              grp <= grp + GW'(1);
              if (grp == LAST) begin
                state <= S_DONE;
                complete <= 1'b1;
              end else begin
                addr <= rd_first;
              end
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.SRAM_we_n = we_n;
  assign bus.SRAM_address = addr;
  assign bus.SRAM_write_data = wdata;
  assign bus.RY_complete = complete;

endmodule

// File: tb/tb_rgb_to_yuv_ds.sv
// tb_rgb_to_yuv_ds: directed bench, behavioural SRAM with 2-cycle reads.
// Image shrunk to N groups to keep runs short.
module tb_rgb_to_yuv_ds;

  localparam int N = 8;
  localparam logic [17:0] YB = 18'd0;
  localparam logic [17:0] UB = 18'd38400;
  localparam logic [17:0] VB = 18'd57600;
  localparam logic [17:0] RB = 18'd146944;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int errors = 0;
  int checks = 0;
  int nwr = 0;
  int w0;

  always #5 clk = ~clk;

  rgb_to_yuv_ds_if bus ();

  rgb_to_yuv_ds #(
    .Y_START_ADDRESS(YB),
    .U_START_ADDRESS(UB),
    .V_START_ADDRESS(VB),
    .RGB_START_ADDRESS(RB),
    .NUM_GROUPS(N)
  ) dut (
    .Clock(clk),
    .Resetn(rst_n),
    .bus(bus)
  );

  logic [15:0] rgb [0:262143];
  logic [15:0] omem [0:262143];
  logic [15:0] pipe1;
  logic [15:0] pat [N][6];
  logic [15:0] ey0 [N];
  logic [15:0] ey1 [N];
  logic [15:0] eu [N];
  logic [15:0] ev [N];

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 2 * N; k++)
        omem[YB + 18'(k)] <= 16'hDEAD;
      for (int k = 0; k < N; k++) begin
        omem[UB + 18'(k)] <= 16'hDEAD;
        omem[VB + 18'(k)] <= 16'hDEAD;
      end
    end else if (!bus.SRAM_we_n) begin
      omem[bus.SRAM_address] <= bus.SRAM_write_data;
      nwr <= nwr + 1;
    end
    pipe1 <= rgb[bus.SRAM_address];
    bus.SRAM_read_data <= pipe1;
  end

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_out();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_image(input string tag);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("%s_y0_g%0d", tag, g),
          32'(omem[YB + 18'(2 * g)]), 32'(ey0[g]));
      chk($sformatf("%s_y1_g%0d", tag, g),
          32'(omem[YB + 18'(2 * g + 1)]), 32'(ey1[g]));
      chk($sformatf("%s_u_g%0d", tag, g),
          32'(omem[UB + 18'(g)]), 32'(eu[g]));
      chk($sformatf("%s_v_g%0d", tag, g),
          32'(omem[VB + 18'(g)]), 32'(ev[g]));
    end
  endtask

  // Enable, then walk the run; stops at cycle stop_t if reached.
  task automatic run_groups(input int stop_t);
    int last;
    logic [17:0] ea;
    logic ew;
    last = 16 * N - 1;
    @(negedge clk);
    bus.RY_enable = 1'b1;
    @(negedge clk);
    bus.RY_enable = 1'b0;
    for (int t = 0; t <= last; t++) begin
      int g;
      int c;
      g = t / 16;
      c = t % 16;
      if (t == stop_t) return;
      if (t == 0 || t == last)
        chk($sformatf("complete_t%0d", t),
            32'(bus.RY_complete), 32'd0);
      if (g == 0 || g == 1 || g == N - 1) begin
        ew = 1'b1;
        ea = 18'd0;
        if (c <= 5) ea = RB + 18'(6 * g + c);
        else if (c == 12) begin
          ew = 1'b0;
          ea = YB + 18'(2 * g);
        end else if (c == 13) begin
          ew = 1'b0;
          ea = YB + 18'(2 * g + 1);
        end else if (c == 14) begin
          ew = 1'b0;
          ea = UB + 18'(g);
        end else if (c == 15) begin
          ew = 1'b0;
          ea = VB + 18'(g);
        end
        if (c >= 6 && c <= 11)
          chk($sformatf("we_g%0d_c%0d", g, c),
              32'(bus.SRAM_we_n), 32'd1);
        else
          chk($sformatf("we_addr_g%0d_c%0d", g, c),
              32'({bus.SRAM_we_n, bus.SRAM_address}),
              32'({ew, ea}));
      end
      if (t == 19) bus.RY_enable = 1'b1;
      @(negedge clk);
      bus.RY_enable = 1'b0;
    end
    chk("complete_done", 32'(bus.RY_complete), 32'd1);
  endtask

  initial begin
    bus.RY_enable = 1'b0;

    pat[0] = '{16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000};
    pat[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF,
               16'hFFFF, 16'hFFFF, 16'hFFFF};
    pat[2] = '{16'hFF00, 16'h00FF, 16'h0000,
               16'hFF00, 16'h00FF, 16'h0000};
    pat[3] = '{16'hFF00, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000};
    pat[4] = '{16'h00FF, 16'h0000, 16'hFF00,
               16'h00FF, 16'h0000, 16'hFF00};
    pat[5] = '{16'h0000, 16'hFF00, 16'h00FF,
               16'h0000, 16'hFF00, 16'h00FF};
    pat[6] = '{16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000};
    pat[7] = '{16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h00FF, 16'h0000};

    ey0 = '{16'h1010, 16'hEBEB, 16'h5252, 16'h5210,
            16'h9191, 16'h2929, 16'h1010, 16'h1010};
    ey1 = '{16'h1010, 16'hEBEB, 16'h5252, 16'h1010,
            16'h9191, 16'h2929, 16'h1010, 16'h1052};
    eu  = '{16'h8080, 16'h8080, 16'h5A5A, 16'h6D80,
            16'h3636, 16'hF0F0, 16'h8080, 16'h806D};
    ev  = '{16'h8080, 16'h8080, 16'hF0F0, 16'hB880,
            16'h2222, 16'h6E6E, 16'h8080, 16'h80B8};

    for (int g = 0; g < N; g++)
      for (int k = 0; k < 6; k++)
        rgb[RB + 18'(6 * g + k)] = pat[g][k];

    repeat (3) @(negedge clk);
    chk("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
    chk("rst_addr", 32'(bus.SRAM_address), 32'd0);
    chk("rst_wdata", 32'(bus.SRAM_write_data), 32'd0);
    chk("rst_complete", 32'(bus.RY_complete), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_we_n", 32'(bus.SRAM_we_n), 32'd1);

    clear_out();
    w0 = nwr;
    run_groups(-1);
    chk("run1_writes", 32'(nwr - w0), 32'(4 * N));
    check_image("run1");

    clear_out();
    chk("done_hold", 32'(bus.RY_complete), 32'd1);
    w0 = nwr;
    run_groups(5 * 16 + 13);
    rst_n = 1'b0;
    #1;
    chk("mid_we_n", 32'(bus.SRAM_we_n), 32'd1);
    chk("mid_addr", 32'(bus.SRAM_address), 32'd0);
    chk("mid_wdata", 32'(bus.SRAM_write_data), 32'd0);
    chk("mid_complete", 32'(bus.RY_complete), 32'd0);
    chk("mid_writes", 32'(nwr - w0), 32'd21);
    chk("mid_y_g5w0", 32'(omem[YB + 18'd10]), 32'(ey0[5]));
    chk("mid_y_g5w1", 32'(omem[YB + 18'd11]), 32'h0000DEAD);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_writes", 32'(nwr - w0), 32'd21);
    chk("post_we_n", 32'(bus.SRAM_we_n), 32'd1);
    chk("post_complete", 32'(bus.RY_complete), 32'd0);

    clear_out();
    w0 = nwr;
    run_groups(-1);
    chk("run3_writes", 32'(nwr - w0), 32'(4 * N));
    check_image("run3");

    clear_out();
    w0 = nwr;
    run_groups(-1);
    chk("run4_writes", 32'(nwr - w0), 32'(4 * N));
    check_image("run4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
